// File: rtl/boot_loader_if.sv
// Byte-stream input and RAM write port of the serial boot loader.
// The slave side belongs to boot_loader; the master side drives bytes and watches writes.
interface boot_loader_if #(
    parameter int RAMSIZE = 12
) ();
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic [RAMSIZE-1:0] ram_address;
    logic [15:0]        ram_din;
    logic               ram_we;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output ram_address,
        output ram_din,
        output ram_we
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  ram_address,
        input  ram_din,
        input  ram_we
    );
endinterface

// File: rtl/boot_loader.sv
// Serial boot loader: parses 0x55 | addr16 | count16 | count x data16 | csum8 from a byte
// stream, writes the words into RAM, then releases the CPU from reset.
module boot_loader #(
    parameter int RAMSIZE = 12,
    parameter int TIMEOUT = 400000
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic          boot_en,
    boot_loader_if.slave  bus,
    output logic          cpu_reset_b,
    output logic          busy,
    output logic          error
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        SYNC, AHI, ALO, CHI, CLO, DHI, DLO, CSUM, RUN
    } state_t;

    state_t             state_q, state_d;
    logic               started_q, started_d;
    logic [7:0]         hi_q, hi_d;
    logic [RAMSIZE-1:0] addr_q, addr_d;
    logic [15:0]        count_q, count_d;
    logic [7:0]         csum_q, csum_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [RAMSIZE-1:0] ram_address_q, ram_address_d;
    logic [15:0]        ram_din_q, ram_din_d;
    logic               ram_we_q, ram_we_d;
    logic               cpu_reset_b_q, cpu_reset_b_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;

    logic [15:0]        word;
    logic               in_frame;
    logic               timed_out;

    assign word      = {hi_q, bus.rx_data};
    assign in_frame  = (state_q inside {AHI, ALO, CHI, CLO, DHI, DLO, CSUM});
    assign timed_out = in_frame && (idle_q == IDLE_W'(TIMEOUT));

    always_comb begin
        // NOTE: every next-state variable gets a default here so no path can infer a latch.
        state_d       = state_q;
        started_d     = 1'b1;
        hi_d          = hi_q;
        addr_d        = addr_q;
        count_d       = count_q;
        csum_d        = csum_q;
        ram_address_d = ram_address_q;
        ram_din_d     = ram_din_q;
        ram_we_d      = 1'b0;
        error_d       = error_q;

        // Saturating idle counter; any received byte restarts it.
        if (bus.rx_valid)
            idle_d = '0;
        else if (idle_q == IDLE_W'(TIMEOUT))
            idle_d = idle_q;
        else
            idle_d = idle_q + IDLE_W'(1);

        if (!started_q && !boot_en) begin
            state_d = RUN;
        end else if (timed_out) begin
            state_d = SYNC;
            error_d = 1'b1;
        end else if (bus.rx_valid) begin
            if (state_q inside {AHI, ALO, CHI, CLO, DHI, DLO})
                csum_d = csum_q + bus.rx_data;

            case (state_q)
                SYNC: begin
                    if (bus.rx_data == 8'h55) begin
                        state_d = AHI;
                        error_d = 1'b0;
                        csum_d  = '0;
                    end
                end
                AHI: begin
                    hi_d    = bus.rx_data;
                    state_d = ALO;
                end
                ALO: begin
                    addr_d  = word[RAMSIZE-1:0];
                    state_d = CHI;
                end
                CHI: begin
                    hi_d    = bus.rx_data;
                    state_d = CLO;
                end
                CLO: begin
                    count_d = word;
                    state_d = (word == 16'd0) ? CSUM : DHI;
                end
                DHI: begin
                    hi_d    = bus.rx_data;
                    state_d = DLO;
                end
                DLO: begin
                    ram_we_d      = 1'b1;
                    ram_din_d     = word;
                    ram_address_d = addr_q;
                    addr_d        = addr_q + RAMSIZE'(1);
                    count_d       = count_q - 16'd1;
                    state_d       = (count_q == 16'd1) ? CSUM : DHI;
                end
                CSUM: begin
                    if (bus.rx_data == csum_q) begin
                        state_d = RUN;
                    end else begin
                        state_d = SYNC;
                        error_d = 1'b1;
                    end
                end
                RUN:     state_d = RUN;
                default: state_d = SYNC;
            endcase
        end

        // Status outputs are registered from the next state so they align with it.
        cpu_reset_b_d = (state_d == RUN);
        busy_d        = (state_d inside {AHI, ALO, CHI, CLO, DHI, DLO, CSUM});
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q       <= SYNC;
            started_q     <= 1'b0;
            hi_q          <= '0;
            addr_q        <= '0;
            count_q       <= '0;
            csum_q        <= '0;
            idle_q        <= '0;
            ram_address_q <= '0;
            ram_din_q     <= '0;
            ram_we_q      <= 1'b0;
            cpu_reset_b_q <= 1'b0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            started_q     <= started_d;
            hi_q          <= hi_d;
            addr_q        <= addr_d;
            count_q       <= count_d;
            csum_q        <= csum_d;
            idle_q        <= idle_d;
            ram_address_q <= ram_address_d;
            ram_din_q     <= ram_din_d;
            ram_we_q      <= ram_we_d;
            cpu_reset_b_q <= cpu_reset_b_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
        end
    end

    assign bus.ram_address = ram_address_q;
    assign bus.ram_din     = ram_din_q;
    assign bus.ram_we      = ram_we_q;
    assign cpu_reset_b     = cpu_reset_b_q;
    assign busy            = busy_q;
    assign error           = error_q;

endmodule
